// File: rtl/ff_bank_scheduler.sv
// ff_bank_scheduler: round-robin sharing of one flip-flop bank between two
// requesters. The granted command is driven on ff_in for HOLD_CYCLES edges,
// the bank outputs are snapshotted one cycle later and returned with a done
// pulse to the requester that issued the command.
module ff_bank_scheduler #(
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       cmd0,
  input  logic [1:0]       cmd1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [3:0]       rsp_data,
  output logic [1:0]       ff_in,
  input  logic             ff_sr,
  input  logic             ff_jk,
  input  logic             ff_d,
  input  logic             ff_t,
  output logic             busy,
  output logic [CNT_W-1:0] issue_cnt
);

  localparam int              HC_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1) begin : g_hold_chk
    $error("ff_bank_scheduler: HOLD_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, RESP} state_t;

  // winning requester (0/1) and the command latched on the grant edge
  typedef struct packed {
    logic       sel;
    logic [1:0] cmd;
  } grant_t;

  state_t           state, state_d;
  grant_t           grant_q, grant_d;
  logic             rr_last, rr_last_d;
  logic [HC_W-1:0]  hold_cnt, hold_cnt_d;
  logic [1:0]       ff_in_d;
  logic             gnt0_d, gnt1_d, done0_d, done1_d;
  logic [3:0]       rsp_d;
  logic [CNT_W-1:0] cnt_d;
  logic             pick0;

  // requester 0 wins when alone, or on a tie when requester 1 was served last
  assign pick0 = req0 & (~req1 | rr_last);
  assign busy  = (state != IDLE);

  // next-state and next registered-output logic
  always_comb begin
    state_d    = state;
    grant_d    = grant_q;
    rr_last_d  = rr_last;
    hold_cnt_d = hold_cnt;
    ff_in_d    = 2'b00;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    rsp_d      = rsp_data;
    cnt_d      = issue_cnt;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          gnt0_d      = pick0;
          gnt1_d      = ~pick0;
          grant_d.sel = ~pick0;
          grant_d.cmd = pick0 ? cmd0 : cmd1;
          ff_in_d     = grant_d.cmd;
          hold_cnt_d  = '0;
          state_d     = DRIVE;
        end
      end
      DRIVE: begin
        // ff_in was loaded on the grant edge, so the last hold cycle
        // hands over to SAMPLE with the bank idle
        if (hold_cnt == HC_LAST) begin
          state_d = SAMPLE;
        end else begin
          hold_cnt_d = hold_cnt + HC_W'(1);
          ff_in_d    = grant_q.cmd;
        end
      end
      SAMPLE: begin
        // bank outputs here already reflect every DRIVE edge
        rsp_d     = {ff_sr, ff_jk, ff_d, ff_t};
        done0_d   = ~grant_q.sel;
        done1_d   = grant_q.sel;
        cnt_d     = issue_cnt + CNT_W'(1);
        rr_last_d = grant_q.sel;
        state_d   = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and registered outputs; reset drops any command in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_q   <= '0;
      rr_last   <= 1'b1;
      hold_cnt  <= '0;
      ff_in     <= 2'b00;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rsp_data  <= '0;
      issue_cnt <= '0;
    end else begin
      state     <= state_d;
      grant_q   <= grant_d;
      rr_last   <= rr_last_d;
      hold_cnt  <= hold_cnt_d;
      ff_in     <= ff_in_d;
      gnt0      <= gnt0_d;
      gnt1      <= gnt1_d;
      done0     <= done0_d;
      done1     <= done1_d;
      rsp_data  <= rsp_d;
      issue_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ff_bank_scheduler.sv
// tb_ff_bank_scheduler: two schedulers (HOLD_CYCLES 1 and 3), each with its
// own behavioural flip-flop bank, checked against a transaction-level model.
module tb_ff_bank_scheduler;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n, brst_n;
  always #5 clk = ~clk;

  logic             req0[2], req1[2];
  logic [1:0]       cmd0[2], cmd1[2];
  logic             gnt0[2], gnt1[2], done0[2], done1[2], busy[2];
  logic [3:0]       rsp[2];
  logic [1:0]       ffin[2];
  logic [CNT_W-1:0] icnt[2];
  logic             bsr[2], bjk[2], bd[2], bt[2];

  ff_bank_scheduler #(.HOLD_CYCLES(1), .CNT_W(CNT_W)) u_dut_h1 (
    .clk(clk), .rst_n(rst_n), .req0(req0[0]), .req1(req1[0]), .cmd0(cmd0[0]), .cmd1(cmd1[0]),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .done0(done0[0]), .done1(done1[0]), .rsp_data(rsp[0]),
    .ff_in(ffin[0]), .ff_sr(bsr[0]), .ff_jk(bjk[0]), .ff_d(bd[0]), .ff_t(bt[0]),
    .busy(busy[0]), .issue_cnt(icnt[0]));

  ff_bank_scheduler #(.HOLD_CYCLES(3), .CNT_W(CNT_W)) u_dut_h3 (
    .clk(clk), .rst_n(rst_n), .req0(req0[1]), .req1(req1[1]), .cmd0(cmd0[1]), .cmd1(cmd1[1]),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .done0(done0[1]), .done1(done1[1]), .rsp_data(rsp[1]),
    .ff_in(ffin[1]), .ff_sr(bsr[1]), .ff_jk(bjk[1]), .ff_d(bd[1]), .ff_t(bt[1]),
    .busy(busy[1]), .issue_cnt(icnt[1]));

  // flip-flop banks: SR(S=in[0],R=in[1]), JK(J=in[1],K=in[0]), D=in[0], T=in[0].
  // SR with S=R=1 is undefined; this stand-in simply holds sr.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!brst_n) begin
        bsr[k] <= 1'b0; bjk[k] <= 1'b0; bd[k] <= 1'b0; bt[k] <= 1'b0;
      end else begin
        case (ffin[k])
          2'b00: bd[k] <= 1'b0;
          2'b01: begin bsr[k] <= 1'b1; bjk[k] <= 1'b0; bd[k] <= 1'b1; bt[k] <= ~bt[k]; end
          2'b10: begin bsr[k] <= 1'b0; bjk[k] <= 1'b1; bd[k] <= 1'b0; end
          default: begin bjk[k] <= ~bjk[k]; bd[k] <= 1'b1; bt[k] <= ~bt[k]; end
        endcase
      end
    end
  end

  int errs = 0, nchk = 0;

  // model: bank contents, last served requester, completed count
  bit               m_sr[2], m_jk[2], m_t[2], m_last[2];
  logic [CNT_W-1:0] m_cnt[2];
  int               ndone[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sr[k] = 0; m_jk[k] = 0; m_t[k] = 0; m_last[k] = 1; m_cnt[k] = '0; ndone[k] = 0;
    end
  endtask

  // bank outputs after h edges of command c
  function automatic logic [3:0] predict(input int k, input logic [1:0] c, input int h);
    bit sr, jk, t;
    sr = m_sr[k]; jk = m_jk[k]; t = m_t[k];
    case (c)
      2'b01: begin sr = 1; jk = 0; end
      2'b10: begin sr = 0; jk = 1; end
      2'b11: jk = jk ^ h[0];
      default: ;
    endcase
    if (c[0]) t = t ^ h[0];
    return {sr, jk, c[0], t};
  endfunction

  task automatic do_reset();
    rst_n = 0; brst_n = 0;
    @(negedge clk);
    rst_n = 1; brst_n = 1;
    model_reset();
  endtask

  // One transaction on instance k; called at a negedge with the DUT idle at the
  // next edge and at least one request raised. Returns at the negedge of the
  // idle cycle that follows, where the next grant may be set up.
  // mode: 0 nothing, 1 raise the loser while busy, 2 raise it then drop it.
  task automatic expect_txn(input int k, input bit keep0, input bit keep1, input int mode,
                            output bit gw);
    int         h, w;
    logic [1:0] c;
    logic [3:0] exp;
    logic [CNT_W-1:0] nc;
    bit         blip;
    h = (k == 0) ? 1 : 3;
    if (req0[k] && req1[k]) w = m_last[k] ? 0 : 1;
    else w = req0[k] ? 0 : 1;
    c    = (w == 0) ? cmd0[k] : cmd1[k];
    exp  = predict(k, c, h);
    nc   = m_cnt[k] + 1'b1;
    blip = 0;
    @(negedge clk);
    chk("gnt0", gnt0[k], w == 0);
    chk("gnt1", gnt1[k], w == 1);
    gw = gnt1[k];
    if (w == 0) begin req0[k] = keep0; if (!keep0) cmd0[k] = 2'($urandom); end
    else        begin req1[k] = keep1; if (!keep1) cmd1[k] = 2'($urandom); end
    for (int i = 0; i <= h + 2; i++) begin
      if (i > 0) @(negedge clk);
      chk("ff_in", ffin[k], (i < h) ? c : 2'b00);
      chk("busy", busy[k], i < h + 2);
      if (i > 0) begin
        chk("gnt0_idle", gnt0[k], 0);
        chk("gnt1_idle", gnt1[k], 0);
      end
      chk("done_win", (w == 1) ? done1[k] : done0[k], i == h + 1);
      chk("done_other", (w == 1) ? done0[k] : done1[k], 0);
      if (i == h + 1) begin
        chk("rsp_data", rsp[k], exp);
        chk("issue_cnt", icnt[k], nc);
        if ((w == 1) ? done1[k] : done0[k]) ndone[k]++;
      end
      if (i == 1 && mode != 0) begin
        if (w == 0 && !req1[k]) begin req1[k] = 1; cmd1[k] = 2'($urandom); blip = (mode == 2); end
        if (w == 1 && !req0[k]) begin req0[k] = 1; cmd0[k] = 2'($urandom); blip = (mode == 2); end
      end
      if (i == 2 && blip) begin
        if (w == 0) req1[k] = 0; else req0[k] = 0;
      end
    end
    m_sr[k] = exp[3]; m_jk[k] = exp[2]; m_t[k] = exp[0];
    m_last[k] = (w == 1); m_cnt[k] = nc;
  endtask

  initial begin
    bit gw;
    int r, guard;
    for (int k = 0; k < 2; k++) begin
      req0[k] = 1; cmd0[k] = 2'b01; req1[k] = 0; cmd1[k] = 2'b00;
    end
    rst_n = 0; brst_n = 0;
    model_reset();

    // reset held with a pending set command: nothing may be granted
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("rst_gnt0", gnt0[k], 0);
        chk("rst_gnt1", gnt1[k], 0);
        chk("rst_ff_in", ffin[k], 2'b00);
        chk("rst_busy", busy[k], 0);
        chk("rst_cnt", icnt[k], '0);
        chk("rst_rsp", rsp[k], 4'h0);
      end
    end
    // drop the requests as reset releases: they must never be granted
    req0[0] = 0; req0[1] = 0;
    rst_n = 1; brst_n = 1;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("drop_gnt0", gnt0[k], 0);
        chk("drop_busy", busy[k], 0);
      end
    end

    // H=1: reset command then set command
    req0[0] = 1; cmd0[0] = 2'b10;
    expect_txn(0, 0, 0, 0, gw);
    chk("h1_rsp_reset", rsp[0], 4'b0100);
    req0[0] = 1; cmd0[0] = 2'b01;
    expect_txn(0, 0, 0, 0, gw);
    chk("h1_rsp_set", rsp[0], 4'b1011);

    // H=3: requester 1 set/toggle with t=0 -> t toggled three times
    req1[1] = 1; cmd1[1] = 2'b01;
    expect_txn(1, 0, 0, 0, gw);
    chk("h3_rsp_t", rsp[1][0], 1'b1);
    chk("h3_owner", gw, 1'b1);

    // both requesters held: strict alternation starting with requester 0
    do_reset();
    req0[0] = 1; cmd0[0] = 2'b10; req1[0] = 1; cmd1[0] = 2'b01;
    for (int n = 0; n < 4; n++) begin
      expect_txn(0, n < 2, n < 2, 0, gw);
      chk("alt_order", gw, n % 2);
    end
    chk("alt_cnt", icnt[0], 8'd4);
    chk("alt_done", ndone[0], 4);

    // a request raised and dropped while busy is never granted
    req0[0] = 1; cmd0[0] = 2'b11;
    expect_txn(0, 0, 0, 2, gw);
    repeat (3) begin
      @(negedge clk);
      chk("blip_gnt1", gnt1[0], 0);
      chk("blip_gnt0", gnt0[0], 0);
    end

    // randomized traffic on both instances
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 30; n++) begin
        if (!req0[k] && !req1[k]) begin
          r = $urandom_range(1, 3);
          if (r[0]) begin req0[k] = 1; cmd0[k] = 2'($urandom); end
          if (r[1]) begin req1[k] = 1; cmd1[k] = 2'($urandom); end
        end else begin
          if (req0[k] && $urandom_range(0, 1) == 1) cmd0[k] = 2'($urandom);
          if (req1[k] && $urandom_range(0, 1) == 1) cmd1[k] = 2'($urandom);
        end
        expect_txn(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), gw);
      end
      guard = 0;
      while ((req0[k] || req1[k]) && guard < 3) begin
        expect_txn(k, 0, 0, 0, gw);
        guard++;
      end
    end

    // reset during the second DRIVE cycle drops the command
    req0[1] = 1; cmd0[1] = 2'b01;
    @(negedge clk);
    chk("mid_gnt", gnt0[1], 1);
    @(negedge clk);
    rst_n = 0; brst_n = 0; req0[1] = 0;
    @(negedge clk);
    chk("mid_ff_in", ffin[1], 2'b00);
    chk("mid_busy", busy[1], 0);
    chk("mid_cnt", icnt[1], '0);
    rst_n = 1; brst_n = 1;
    model_reset();
    repeat (6) begin
      @(negedge clk);
      chk("mid_done0", done0[1], 0);
      chk("mid_done1", done1[1], 0);
      chk("mid_idle", busy[1], 0);
    end

    // 256 back-to-back commands from requester 0: counter wraps
    do_reset();
    req0[0] = 1; cmd0[0] = 2'($urandom);
    for (int n = 1; n <= 256; n++) begin
      cmd0[0] = 2'($urandom);
      expect_txn(0, n < 256, 0, 0, gw);
      if (n == 255) chk("wrap_255", icnt[0], 8'd255);
      if (n == 256) chk("wrap_0", icnt[0], 8'd0);
    end
    chk("wrap_done", ndone[0], 256);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
